calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 154 +++++++++++++++
 tb/tb_calc_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: button-driven multi-operand calculator.
// The user enters NUM_OPS operands one confirm press at a time. The first
// operand loads the accumulator, and each later operand is folded in with
// the selected operator. The finished value is then held in DONE until a
// clear request arrives.
module calc_sequencer #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 2,
    localparam int IDXW   = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             confirm,
    input  logic             clear,
    input  logic [WIDTH-1:0] operand_in,
    input  logic [1:0]       opcode_in,
    output logic [2:0]       state,
    output logic [IDXW-1:0]  op_idx,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTER    = 3'd1,
        WAIT_REL = 3'd2,
        CALC     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_OPS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_d;
    logic               ovf_step;
    logic               armed;
    logic               capture;
    logic               busy_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    assign state = state_q;

    // A press is taken only in ENTER, only once confirm has been seen low
    // since the last capture or restart, and never while clear is pending.
    assign capture = (state_q == ENTER) && confirm && armed && !clear;

    assign sum  = {1'b0, acc} + {1'b0, operand_in};
    assign prod = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, operand_in};

    // Next-state selection; clear overrides everything, and unused codes fall back to IDLE.
    always_comb begin
        state_d = IDLE;
        if (!clear) begin
            case (state_q)
                IDLE:     state_d = ENTER;
                ENTER:    state_d = (confirm && armed) ? WAIT_REL : ENTER;
                WAIT_REL: begin
                    if (confirm)
                        state_d = WAIT_REL;
                    else if (op_idx == LAST_IDX)
                        state_d = CALC;
                    else
                        state_d = ENTER;
                end
                CALC:     state_d = DONE;
                DONE:     state_d = DONE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Accumulator update and per-step overflow detection for the operand being captured.
    always_comb begin
        acc_d    = acc;
        ovf_step = 1'b0;
        if (op_idx == '0) begin
            acc_d = operand_in;
        end else begin
            case (opcode_in)
                2'b00: begin
                    acc_d    = sum[WIDTH-1:0];
                    ovf_step = sum[WIDTH];
                end
                2'b01: begin
                    acc_d    = acc - operand_in;
                    ovf_step = (operand_in > acc);
                end
                2'b10: begin
                    acc_d    = prod[WIDTH-1:0];
                    ovf_step = |prod[2*WIDTH-1:WIDTH];
                end
                default: begin
                    acc_d    = acc ^ operand_in;
                    ovf_step = 1'b0;
                end
            endcase
        end
    end

    // busy is registered from the upcoming state so the output has no combinational decode.
    always_comb begin
        busy_d = (state_d == ENTER) || (state_d == WAIT_REL) || (state_d == CALC);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Operand index, accumulator, result holding, and the press-arming flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_idx       <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            armed        <= 1'b0;
            busy         <= 1'b0;
        end else if (clear) begin
            op_idx       <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            armed        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy <= busy_d;
            if (capture) begin
                acc      <= acc_d;
                overflow <= overflow | ovf_step;
                armed    <= 1'b0;
            end else if (!confirm) begin
                armed <= 1'b1;
            end
            if ((state_q == WAIT_REL) && !confirm && (op_idx != LAST_IDX))
                op_idx <= op_idx + IDXW'(1);
            if (state_q == CALC) begin
                result       <= acc;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer.
// dut2 is the two-operand build and dut3 is the three-operand build.
// Both instances share every input.
module tb_calc_sequencer;

    logic       clk;
    logic       reset_n;
    logic       confirm;
    logic       clear;
    logic [7:0] operand_in;
    logic [1:0] opcode_in;

    logic [2:0] state2, state3;
    logic [0:0] op_idx2;
    logic [1:0] op_idx3;
    logic [7:0] result2, result3;
    logic       rv2, rv3, ovf2, ovf3, busy2, busy3;

    int passed = 0;
    int total  = 0;

    calc_sequencer #(.WIDTH(8), .NUM_OPS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .confirm(confirm), .clear(clear),
        .operand_in(operand_in), .opcode_in(opcode_in),
        .state(state2), .op_idx(op_idx2), .result(result2),
        .result_valid(rv2), .overflow(ovf2), .busy(busy2)
    );

    calc_sequencer #(.WIDTH(8), .NUM_OPS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .confirm(confirm), .clear(clear),
        .operand_in(operand_in), .opcode_in(opcode_in),
        .state(state3), .op_idx(op_idx3), .result(result3),
        .result_valid(rv3), .overflow(ovf3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] code;
        logic [7:0] exp_res;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves both DUTs in ENTER at op_idx 0, armed.
    task automatic do_clear();
        clear   = 1'b1;
        confirm = 1'b0;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic press(input logic [7:0] op, input logic [1:0] code);
        operand_in = op;
        opcode_in  = code;
        confirm    = 1'b1;
        tick();
        confirm = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{8'd25,  8'd17,  2'b00, 8'd42,  1'b0};
        vecs[1] = '{8'd200, 8'd100, 2'b00, 8'd44,  1'b1};
        vecs[2] = '{8'd5,   8'd9,   2'b01, 8'd252, 1'b1};
        vecs[3] = '{8'd9,   8'd5,   2'b01, 8'd4,   1'b0};
        vecs[4] = '{8'd16,  8'd16,  2'b10, 8'd0,   1'b1};
        vecs[5] = '{8'd15,  8'd17,  2'b10, 8'd255, 1'b0};
        vecs[6] = '{8'hAA,  8'hFF,  2'b11, 8'h55,  1'b0};
        vecs[7] = '{8'd255, 8'd1,   2'b00, 8'd0,   1'b1};
        vecs[8] = '{8'd100, 8'd100, 2'b01, 8'd0,   1'b0};
        vecs[9] = '{8'd12,  8'd20,  2'b10, 8'd240, 1'b0};

        reset_n    = 1'b0;
        confirm    = 1'b0;
        clear      = 1'b0;
        operand_in = '0;
        opcode_in  = '0;
        #12;
        check("reset_state",  int'(state2),  0);
        check("reset_op_idx", int'(op_idx2), 0);
        check("reset_result", int'(result2), 0);
        check("reset_rv",     int'(rv2),     0);
        check("reset_ovf",    int'(ovf2),    0);
        check("reset_busy",   int'(busy2),   0);
        reset_n = 1'b1;
        tick();
        check("idle_to_enter", int'(state2), 1);
        check("enter_busy",    int'(busy2),  1);

        // Two-operand vectors, with result_valid latency checked on each one.
        for (int i = 0; i < 10; i++) begin
            do_clear();
            press(vecs[i].a, 2'b00);
            press(vecs[i].b, vecs[i].code);
            check($sformatf("v%0d_rv_at_release_edge", i), int'(rv2), 0);
            tick();
            check($sformatf("v%0d_rv", i),     int'(rv2),     1);
            check($sformatf("v%0d_result", i), int'(result2), int'(vecs[i].exp_res));
            check($sformatf("v%0d_ovf", i),    int'(ovf2),    int'(vecs[i].exp_ovf));
            check($sformatf("v%0d_state", i),  int'(state2),  4);
        end
        check("done_busy", int'(busy2), 0);

        // Confirm held for 50 cycles gives exactly one capture.
        do_clear();
        operand_in = 8'd7;
        opcode_in  = 2'b00;
        confirm    = 1'b1;
        repeat (50) tick();
        check("held_state",  int'(state2),  2);
        check("held_op_idx", int'(op_idx2), 0);
        confirm = 1'b0;
        tick();
        check("held_release_op_idx", int'(op_idx2), 1);
        check("held_release_state",  int'(state2),  1);
        press(8'd3, 2'b00);
        tick();
        check("held_result", int'(result2), 10);

        // Clear and confirm together in ENTER at op_idx 1: clear wins and nothing is captured.
        do_clear();
        press(8'd10, 2'b00);
        operand_in = 8'd50;
        confirm    = 1'b1;
        clear      = 1'b1;
        tick();
        check("clr_conf_state",  int'(state2),  0);
        check("clr_conf_op_idx", int'(op_idx2), 0);
        clear   = 1'b0;
        confirm = 1'b0;
        tick();
        check("clr_conf_reenter", int'(state2), 1);
        press(8'd1, 2'b00);
        press(8'd2, 2'b00);
        tick();
        check("clr_conf_result", int'(result2), 3);

        // Confirm is ignored in DONE; clear drops result_valid; a held press must be released before it is taken.
        confirm = 1'b1;
        tick();
        check("done_ignore_rv",     int'(rv2),     1);
        check("done_ignore_result", int'(result2), 3);
        clear = 1'b1;
        tick();
        check("clr_done_rv",     int'(rv2),     0);
        check("clr_done_result", int'(result2), 0);
        clear = 1'b0;
        tick();
        repeat (3) tick();
        check("held_across_clear_state",  int'(state2),  1);
        check("held_across_clear_op_idx", int'(op_idx2), 0);
        confirm = 1'b0;
        tick();
        press(8'd5, 2'b00);
        press(8'd6, 2'b00);
        tick();
        check("held_across_clear_result", int'(result2), 11);

        // Three-operand sequence on dut3.
        do_clear();
        check("n3_idx0", int'(op_idx3), 0);
        press(8'd3, 2'b00);
        check("n3_idx1", int'(op_idx3), 1);
        press(8'd4, 2'b10);
        check("n3_idx2", int'(op_idx3), 2);
        press(8'd2, 2'b01);
        tick();
        check("n3_result", int'(result3), 10);
        check("n3_ovf",    int'(ovf3),    0);
        check("n3_rv",     int'(rv3),     1);
        repeat (2) tick();
        check("n3_idx_hold", int'(op_idx3), 2);

        // Asynchronous reset pulsed between edges while in WAIT_REL.
        do_clear();
        operand_in = 8'd9;
        confirm    = 1'b1;
        tick();
        check("pre_reset_state", int'(state2), 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_state",  int'(state2),  0);
        check("async_op_idx", int'(op_idx2), 0);
        check("async_busy",   int'(busy2),   0);
        check("async_rv",     int'(rv2),     0);
        #1;
        reset_n = 1'b1;
        confirm = 1'b0;
        tick();
        check("post_reset_enter", int'(state2), 1);
        press(8'd30, 2'b00);
        press(8'd12, 2'b00);
        tick();
        check("post_reset_result", int'(result2), 42);
        check("post_reset_ovf",    int'(ovf2),    0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
